// File: rtl/fifo_out_stage.sv
// Two-entry register queue that absorbs the RAM read latency and presents
// the FIFO head word.
module fifo_out_stage #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  head_q, tail_q;
  logic [1:0]            count_q, count_d;

  always_comb begin
    count_d = count_q + {1'b0, wr} - {1'b0, rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (wr) begin
        data_q[tail_q] <= wdata;
        tail_q         <= ~tail_q;
      end
      if (rd) begin
        head_q <= ~head_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata = data_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external simple-dual-port
// RAM with one cycle of registered read latency.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic [ADDRESS_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic [ADDRESS_WIDTH+1:0] level
);

  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CntW  = ADDRESS_WIDTH + 1;
  localparam int unsigned LvlW  = ADDRESS_WIDTH + 2;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [ADDRESS_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]          mem_count_q, mem_count_d;
  logic                     rd_pending_q, in_ready_q, in_ready_d;
  logic                     push, pop, rd;
  logic [1:0]               oq_count;
  logic [2:0]               oq_after_pop;

  always_comb begin
    push = in_valid & in_ready_q;
    pop  = out_valid & out_ready;
    // Slots the output queue will hold once this cycle's pop is taken,
    // counting a read already in flight.
    oq_after_pop = {1'b0, oq_count} + {2'b0, rd_pending_q} - {2'b0, pop};
    rd           = (mem_count_q != '0) && (oq_after_pop < 3'd2);
    mem_count_d  = mem_count_q + CntW'(push) - CntW'(rd);
    in_ready_d   = mem_count_d < DepthCnt;
    wptr_d       = wptr_q + ADDRESS_WIDTH'(push);
    rptr_d       = rptr_q + ADDRESS_WIDTH'(rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      mem_count_q  <= '0;
      rd_pending_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      mem_count_q  <= mem_count_d;
      rd_pending_q <= rd;
      in_ready_q   <= in_ready_d;
    end
  end

  fifo_out_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (rd_pending_q),
    .wdata (ram_rdata),
    .rd    (pop),
    .rdata (out_data),
    .count (oq_count)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = (oq_count != 2'd0);
  assign ram_we    = push;
  assign ram_waddr = wptr_q;
  assign ram_wdata = in_data;
  assign ram_raddr = rptr_q;
  assign level     = LvlW'(mem_count_q) + LvlW'(rd_pending_q) + LvlW'(oq_count);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl with a behavioural RAM and a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, ram_we;
  logic [DW-1:0] in_data, out_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [AW+1:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_q[$];

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .level     (level)
  );

  // Behavioural no_rw_check RAM: a read colliding with a same-cycle write returns garbage.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_we && ram_raddr == ram_waddr) ram_rdata <= DW'($urandom);
    else                                  ram_rdata <= mem[ram_raddr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model, check level after it.
  task automatic cycle(output logic pushed, output logic popped, output logic [DW-1:0] pval);
    logic [DW-1:0] wd;
    #1;
    pushed = in_valid & in_ready;
    popped = out_valid & out_ready;
    pval   = out_data;
    wd     = in_data;
    @(posedge clk);
    if (pushed) model_q.push_back(wd);
    if (popped) begin
      if (model_q.size() == 0) check("pop_underflow", 1, 0);
      else check("pop_order", int'(pval), int'(model_q.pop_front()));
    end
    #1;
    check("level", int'(level), model_q.size());
  endtask

  task automatic fill(input logic [DW-1:0] base, input int max_words, output int acc);
    logic p, q;
    logic [DW-1:0] v;
    acc       = 0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 40 && acc < max_words; i++) begin
      in_data = DW'(base + DW'(acc));
      cycle(p, q, v);
      if (p) acc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int exp_pops);
    logic p, q;
    logic [DW-1:0] v;
    int pops = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 && (level != 0 || out_valid); i++) begin
      cycle(p, q, v);
      if (q) pops++;
    end
    check({name, "_pops"}, pops, exp_pops);
    check({name, "_level"}, int'(level), 0);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic          chk_data;
    logic [DW-1:0] exp_od;
    int            exp_lvl;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p, q;
    logic [DW-1:0] v, first_val;
    int acc, pushes, pops, first_pop, last_pop, max_lvl, idx, cyc;

    // Single word with 2-edge fall-through, then two words buffered and popped.
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1};
    vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_level", int'(level), 0);
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      cycle(p, q, v);
      check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_ir));
      check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_ov));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_out_data", i), int'(out_data), int'(vecs[i].exp_od));
      check($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_lvl);
    end

    // Continuous stream: no bubbles once primed, level tops out at 3.
    idx = 0; pops = 0; first_pop = -1; last_pop = -1; max_lvl = 0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = '0;
    for (int c = 0; c < 200 && pops < 32; c++) begin
      in_valid = (idx < 32);
      in_data  = DW'(idx);
      cycle(p, q, v);
      if (p) idx++;
      if (q) begin
        pops++;
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    check("stream_pops", pops, 32);
    check("stream_no_bubbles", last_pop - first_pop, 31);
    check("stream_level_max", max_lvl, 3);

    // Capacity is D+2 words.
    fill(8'h40, 100, acc);
    check("fill_accepted", acc, 10);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_level", int'(level), 10);
    drain("fill_drain", 10);
    check("drain_in_ready", int'(in_ready), 1);

    // Full FIFO with both sides active: one in per one out after the first cycle.
    fill(8'h80, 100, acc);
    check("full_accepted", acc, 10);
    pushes = 0; pops = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = DW'(8'h90 + DW'(pushes));
      cycle(p, q, v);
      if (c == 0) check("full_first_push", int'(p), 0);
      pushes += int'(p);
      pops   += int'(q);
    end
    check("full_pushes", pushes, 19);
    check("full_pops", pops, 20);
    drain("full_drain", 9);

    // Random traffic against the model.
    pushes = 0; cyc = 0;
    while (pushes < 2000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      cycle(p, q, v);
      pushes += int'(p);
      cyc++;
    end
    check("random_pushes", pushes, 2000);
    drain("random_drain", model_q.size());

    // Asynchronous reset with six words held.
    fill(8'h60, 6, acc);
    check("prereset_accepted", acc, 6);
    #3 rst_n = 1'b0;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_in_ready", int'(in_ready), 0);
    check("async_level", int'(level), 0);
    model_q.delete();
    @(posedge clk);
    #4 rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    idx = 0; first_val = '0; pops = 0;
    for (int c = 0; c < 30 && pops < 3; c++) begin
      in_valid = (idx < 3);
      in_data  = DW'(8'hC0 + DW'(idx));
      cycle(p, q, v);
      if (p) idx++;
      if (q) begin
        if (pops == 0) first_val = v;
        pops++;
      end
    end
    check("postreset_pops", pops, 3);
    check("postreset_first", int'(first_val), 'hC0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
